// File: rtl/dbus_responder.sv
// RAM-backed data-bus target: fixed LATENCY from acceptance to data_ok, byte-strobe writes, err on out-of-range.
// Optional DBUS_RESP_RANDOM_STALL_EN adds 0-3 LFSR-chosen stall cycles per access; no backpressure once accepted.
package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module dbus_responder
  import dbus_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter int          LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       err,
  output logic       busy
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) << 3;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [63:0] r_addr;
  logic [2:0]  r_size;
  logic [7:0]  r_strobe;
  logic [63:0] r_wdata;
  logic        r_data_ok;
  logic        r_err;
  logic [63:0] r_rdata;
  logic [63:0] r_mem [MEM_WORDS];

  logic [63:0]   w_addr;
  logic [63:0]   w_off;
  logic          w_in_range;
  logic [AW-1:0] w_idx;
  logic          w_accept;
  logic [4:0]    w_lat_m1;
  logic          w_go_resp;
  logic          w_unused;

  // In IDLE the live request is decoded so a LATENCY of 1 can read the array on the acceptance edge.
  assign w_addr     = (r_state == IDLE) ? dreq.addr : r_addr;
  assign w_off      = w_addr - BASE_ADDR;
  assign w_in_range = (w_addr >= BASE_ADDR) && (w_off < MEM_BYTES);
  assign w_idx      = w_off[AW+2:3];
  assign w_accept   = (r_state == IDLE) && dreq.valid && !reset;
  assign w_unused   = ^{r_size, w_off[2:0], w_off[63:AW+3]};

`ifdef DBUS_RESP_RANDOM_STALL_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_lat_m1 = 5'(LATENCY - 1) + {3'b000, r_lfsr[1:0]};
`else
  assign w_lat_m1 = 5'(LATENCY - 1);
`endif

  assign w_go_resp = (w_accept && (w_lat_m1 == 5'd0)) ||
                     ((r_state == WAIT) && (r_cnt == 5'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_size    <= '0;
      r_strobe  <= '0;
      r_wdata   <= '0;
      r_data_ok <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_data_ok <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      case (r_state)
        IDLE: begin
          if (dreq.valid) begin
            r_addr   <= dreq.addr;
            r_size   <= dreq.size;
            r_strobe <= dreq.strobe;
            r_wdata  <= dreq.data;
            r_cnt    <= w_lat_m1;
            r_state  <= (w_lat_m1 == 5'd0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) r_state <= RESP;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      // Stores also return the pre-write word, so the read happens for every access.
      if (w_go_resp) begin
        r_data_ok <= 1'b1;
        r_err     <= !w_in_range;
        r_rdata   <= w_in_range ? r_mem[w_idx] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && (r_state == RESP) && w_in_range && (r_strobe != 8'h00)) begin
      for (int i = 0; i < 8; i++) begin
        if (r_strobe[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  assign dresp.addr_ok = w_accept;
  assign dresp.data_ok = r_data_ok;
  assign dresp.data    = r_rdata;
  assign err           = r_err;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench for dbus_responder with default parameters (LATENCY=2, BASE 0x8000_0000, 4096 words).
module tb_dbus_responder;
  import dbus_pkg::*;

  logic       clk;
  logic       reset;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic       err;
  logic       busy;

  int n_cmp;
  int n_bad;

  dbus_responder dut (
    .clk   (clk),
    .reset (reset),
    .dreq  (dreq),
    .dresp (dresp),
    .err   (err),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the request until data_ok, then drops valid; returns in the RESP cycle.
  task automatic access(input string tag, input logic [63:0] a, input logic [7:0] s,
                        input logic [63:0] d, output logic [63:0] rd, output logic e,
                        output int lat);
    dreq.valid  = 1'b1;
    dreq.addr   = a;
    dreq.size   = 3'd3;
    dreq.strobe = s;
    dreq.data   = d;
    #1;
    check({tag, ".addr_ok"}, 64'(dresp.addr_ok), 64'd1);
    lat = 0;
    rd  = '0;
    e   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (dresp.data_ok) break;
    end
    if (!dresp.data_ok) check({tag, ".timeout"}, 64'd0, 64'd1);
    rd = dresp.data;
    e  = err;
    check({tag, ".busy_resp"}, 64'(busy), 64'd1);
    check({tag, ".addr_ok_resp"}, 64'(dresp.addr_ok), 64'd0);
    dreq.valid = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [63:0] a, input logic [7:0] s,
                          input logic [63:0] d, input logic exp_err);
    logic [63:0] rd;
    logic        e;
    int          lat;
    access(tag, a, s, d, rd, e, lat);
    check({tag, ".err"}, 64'(e), 64'(exp_err));
    tick();
  endtask

  task automatic do_read(input string tag, input logic [63:0] a, input logic [63:0] exp,
                         input logic exp_err);
    logic [63:0] rd;
    logic        e;
    int          lat;
    access(tag, a, 8'h00, 64'h0, rd, e, lat);
    check({tag, ".lat"}, 64'(lat), 64'd2);
    check({tag, ".data"}, rd, exp);
    check({tag, ".err"}, 64'(e), 64'(exp_err));
    tick();
    check({tag, ".data_after"}, dresp.data, 64'h0);
    check({tag, ".busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [63:0] rd;
    logic        e;
    int          lat;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    dreq  = '0;
    repeat (3) tick();
    check("rst.addr_ok", 64'(dresp.addr_ok), 64'd0);
    check("rst.data_ok", 64'(dresp.data_ok), 64'd0);
    check("rst.data", dresp.data, 64'h0);
    check("rst.err", 64'(err), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    reset = 1'b0;
    tick();

    // Preload word 0x10, word 0, word 0x11 and the last word through the bus.
    do_write("pre10", 64'h8000_0080, 8'hFF, 64'h1122_3344_5566_7788, 1'b0);
    do_write("pre0", 64'h8000_0000, 8'hFF, 64'hA5A5_0000_0000_5A5A, 1'b0);
    do_write("pre11", 64'h8000_0088, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0);
    do_write("prelast", 64'h8000_7FF8, 8'hFF, 64'hCAFE_F00D_0000_0001, 1'b0);

    do_read("rd_hit", 64'h8000_0080, 64'h1122_3344_5566_7788, 1'b0);
    do_read("rd_last", 64'h8000_7FF8, 64'hCAFE_F00D_0000_0001, 1'b0);

    // Strobed store: the store's own response is the pre-write word.
    do_write("fill", 64'h8000_0080, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    access("st_f0", 64'h8000_0084, 8'hF0, 64'hDEAD_BEEF_0000_0000, rd, e, lat);
    check("st_f0.lat", 64'(lat), 64'd2);
    check("st_f0.old", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    do_read("rd_f0", 64'h8000_0080, 64'hDEAD_BEEF_FFFF_FFFF, 1'b0);

    // Back-to-back reads with valid held across data_ok.
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h8000_0080;
    dreq.strobe = 8'h00;
    #1;
    check("b2b.addr_ok1", 64'(dresp.addr_ok), 64'd1);
    tick();
    check("b2b.wait1", 64'(dresp.data_ok), 64'd0);
    tick();
    check("b2b.ok1", 64'(dresp.data_ok), 64'd1);
    check("b2b.data1", dresp.data, 64'hDEAD_BEEF_FFFF_FFFF);
    dreq.addr = 64'h8000_0088;
    tick();
    check("b2b.addr_ok2", 64'(dresp.addr_ok), 64'd1);
    check("b2b.idle_ok", 64'(dresp.data_ok), 64'd0);
    tick();
    check("b2b.wait2", 64'(dresp.data_ok), 64'd0);
    tick();
    check("b2b.ok2", 64'(dresp.data_ok), 64'd1);
    check("b2b.data2", dresp.data, 64'h0123_4567_89AB_CDEF);
    dreq.valid = 1'b0;
    tick();

    // Out of range, including both edges of the window.
    do_read("oor_rd", 64'h0000_1000, 64'h0, 1'b1);
    do_read("oor_top", 64'h8000_8000, 64'h0, 1'b1);
    do_write("oor_st", 64'h7FFF_FFF8, 8'hFF, 64'h1234_1234_1234_1234, 1'b1);
    do_read("oor_w0", 64'h8000_0000, 64'hA5A5_0000_0000_5A5A, 1'b0);
    do_read("oor_wl", 64'h8000_7FF8, 64'hCAFE_F00D_0000_0001, 1'b0);

    // Request changed during WAIT: captured read of 0x80 wins, no write to 0x88.
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h8000_0080;
    dreq.strobe = 8'h00;
    tick();
    check("chg.busy", 64'(busy), 64'd1);
    dreq.addr   = 64'h8000_0088;
    dreq.strobe = 8'hFF;
    dreq.data   = 64'h5555_5555_5555_5555;
    tick();
    check("chg.ok", 64'(dresp.data_ok), 64'd1);
    check("chg.data", dresp.data, 64'hDEAD_BEEF_FFFF_FFFF);
    dreq.valid  = 1'b0;
    dreq.strobe = 8'h00;
    tick();
    do_read("chg.rd88", 64'h8000_0088, 64'h0123_4567_89AB_CDEF, 1'b0);

    // Reset during WAIT of a full-strobe store.
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h8000_0080;
    dreq.strobe = 8'hFF;
    dreq.data   = 64'hAAAA_AAAA_AAAA_AAAA;
    tick();
    check("rstw.busy", 64'(busy), 64'd1);
    reset      = 1'b1;
    dreq.valid = 1'b0;
    tick();
    reset = 1'b0;
    check("rstw.busy_after", 64'(busy), 64'd0);
    check("rstw.no_ok", 64'(dresp.data_ok), 64'd0);
    tick();
    check("rstw.no_ok2", 64'(dresp.data_ok), 64'd0);
    do_read("rstw.rd", 64'h8000_0080, 64'hDEAD_BEEF_FFFF_FFFF, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
